// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared definitions for the SPI ADC poller.
//   state_t   - poller FSM states
//   CMD_*     - fixed fields of the 8-bit ADC command word
//   cmd_word  - builds {start, single-ended, ch[2:0], 000}
package spi_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ISSUE,
        BUSY,
        STORE
    } state_t;

    localparam logic [1:0] CMD_HDR  = 2'b11;   // start bit + single-ended select
    localparam logic [2:0] CMD_TAIL = 3'b000;  // don't-care padding clocks

    function automatic logic [7:0] cmd_word(input logic [2:0] ch);
        return {CMD_HDR, ch, CMD_TAIL};
    endfunction

endpackage

// File: rtl/poll_counter.sv
// poll_counter: loadable down-counter used for both the inter-conversion
// interval and the SPI completion timeout.
//   clk, reset  - system clock, async active-high reset (count -> 0)
//   load        - load load_val (has priority over dec)
//   load_val    - value to load
//   dec         - decrement by one, saturating at zero
//   zero        - count == 0
module poll_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_adc_poller.sv
// spi_adc_poller: round-robin scanner of an SPI ADC. After INTERVAL idle
// cycles it issues one command frame to the SPI master, waits (bounded by
// TIMEOUT) for completion, and stores the result per channel.
//   clk, reset                 - system clock, async active-high reset
//   enable                     - scanning allowed (level)
//   clear_err                  - pulse; clears timeout_err
//   spi_stb_wr, spi_to_data,
//   spi_total_len              - frame request to the SPI master
//   spi_stb_rdy, spi_from_data - frame completion from the SPI master
//   rd_addr, rd_data           - combinational result read port
//   valid                      - per-channel "holds a good sample"
//   sample_stb, sample_ch      - pulse + channel when a result is stored
//   timeout_err                - sticky SPI timeout flag
module spi_adc_poller
    import spi_adc_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int RES_BITS  = 12,
    parameter int TOTAL_LEN = 19,
    parameter int INTERVAL  = 1000,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear_err,
    output logic                spi_stb_wr,
    output logic [7:0]          spi_to_data,
    output logic [4:0]          spi_total_len,
    input  logic                spi_stb_rdy,
    input  logic [RES_BITS-1:0] spi_from_data,
    input  logic [2:0]          rd_addr,
    output logic [RES_BITS-1:0] rd_data,
    output logic [CHANNELS-1:0] valid,
    output logic                sample_stb,
    output logic [2:0]          sample_ch,
    output logic                timeout_err
);

    localparam int IV_W = $clog2(INTERVAL + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t state, next_state;

    logic [2:0]          ch;
    logic [RES_BITS-1:0] cap_q;
    logic [RES_BITS-1:0] result [CHANNELS];

    logic iv_load, iv_dec, iv_zero;
    logic to_load, to_dec, to_zero;
    logic capture, store, tmo;

    poll_counter #(.W(IV_W)) u_interval (
        .clk      (clk),
        .reset    (reset),
        .load     (iv_load),
        .load_val (IV_W'(INTERVAL - 1)),
        .dec      (iv_dec),
        .zero     (iv_zero)
    );

    poll_counter #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT - 1)),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Every entry into WAIT reloads the interval so spacing is fixed
    // regardless of which path (enable, store, timeout) got us there.
    always_comb begin
        next_state = state;
        spi_stb_wr = 1'b0;
        iv_load    = 1'b0;
        iv_dec     = 1'b0;
        to_load    = 1'b0;
        to_dec     = 1'b0;
        capture    = 1'b0;
        store      = 1'b0;
        tmo        = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    next_state = WAIT;
                    iv_load    = 1'b1;
                end
            end
            WAIT: begin
                if (!enable)
                    next_state = IDLE;
                else if (iv_zero)
                    next_state = ISSUE;
                else
                    iv_dec = 1'b1;
            end
            ISSUE: begin
                spi_stb_wr = 1'b1;
                to_load    = 1'b1;
                next_state = BUSY;
            end
            // enable is deliberately ignored here: a frame in flight
            // always runs to completion or timeout.
            BUSY: begin
                if (spi_stb_rdy) begin
                    capture    = 1'b1;
                    next_state = STORE;
                end else if (to_zero) begin
                    tmo        = 1'b1;
                    iv_load    = 1'b1;
                    next_state = WAIT;
                end else begin
                    to_dec = 1'b1;
                end
            end
            STORE: begin
                store = 1'b1;
                if (enable) begin
                    iv_load    = 1'b1;
                    next_state = WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign spi_to_data   = cmd_word(ch);
    assign spi_total_len = 5'(TOTAL_LEN);

    // rdy is captured in BUSY, written in STORE and announced one cycle
    // later, giving the fixed two-cycle rdy -> sample_stb latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch          <= '0;
            cap_q       <= '0;
            sample_stb  <= 1'b0;
            sample_ch   <= '0;
            timeout_err <= 1'b0;
        end else begin
            sample_stb <= store;
            if (capture)
                cap_q <= spi_from_data;
            if (store)
                sample_ch <= ch;
            if (store || tmo)
                ch <= (ch == 3'(CHANNELS - 1)) ? 3'd0 : ch + 3'd1;
            // a new timeout wins over a coincident clear
            if (tmo)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [RES_BITS-1:0] res_q;
        logic                vld_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                res_q <= '0;
                vld_q <= 1'b0;
            end else if (store && ch == 3'(n)) begin
                res_q <= cap_q;
                vld_q <= 1'b1;
            end
        end

        assign result[n] = res_q;
        assign valid[n]  = vld_q;
    end

    // addresses with no channel behind them read as zero
    always_comb begin
        rd_data = '0;
        for (int n = 0; n < CHANNELS; n++)
            if (rd_addr == 3'(n))
                rd_data = result[n];
    end

endmodule

// File: tb/tb_spi_adc_poller.sv
module tb_spi_adc_poller;

    localparam int INTERVAL = 4;
    localparam int TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic        spi_stb_rdy = 1'b0;
    logic [11:0] spi_from_data = '0;
    logic [2:0]  rd_addr = '0;

    logic        spi_stb_wr, sample_stb, timeout_err;
    logic [7:0]  spi_to_data, valid;
    logic [4:0]  spi_total_len;
    logic [11:0] rd_data;
    logic [2:0]  sample_ch;

    logic        spi_stb_wr4, sample_stb4, timeout_err4;
    logic [7:0]  spi_to_data4;
    logic [4:0]  spi_total_len4;
    logic [11:0] rd_data4;
    logic [3:0]  valid4;
    logic [2:0]  sample_ch4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int sample_cnt = 0;
    int wr_cnt  = 0;

    spi_adc_poller #(.CHANNELS(8), .RES_BITS(12), .TOTAL_LEN(19),
                     .INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .spi_stb_wr(spi_stb_wr), .spi_to_data(spi_to_data),
        .spi_total_len(spi_total_len), .spi_stb_rdy(spi_stb_rdy),
        .spi_from_data(spi_from_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .valid(valid), .sample_stb(sample_stb), .sample_ch(sample_ch),
        .timeout_err(timeout_err)
    );

    // narrower instance sharing all inputs: checks 4-channel wrap and
    // zero reads above CHANNELS
    spi_adc_poller #(.CHANNELS(4), .RES_BITS(12), .TOTAL_LEN(19),
                     .INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
        .spi_stb_wr(spi_stb_wr4), .spi_to_data(spi_to_data4),
        .spi_total_len(spi_total_len4), .spi_stb_rdy(spi_stb_rdy),
        .spi_from_data(spi_from_data), .rd_addr(rd_addr), .rd_data(rd_data4),
        .valid(valid4), .sample_stb(sample_stb4), .sample_ch(sample_ch4),
        .timeout_err(timeout_err4)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sample_stb) sample_cnt++;
        if (spi_stb_wr) wr_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; clear_err = 1'b0; spi_stb_rdy = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        sample_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic wait_wr(input int max, output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        while (waited < max && !ok) begin
            tick();
            waited++;
            if (spi_stb_wr) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        #1;
        n_tests++; if (spi_stb_wr !== 1'b0) begin n_fail++; $display("FAIL reset_stb_wr: got %b expected 0", spi_stb_wr); end
        n_tests++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL reset_sample_stb: got %b expected 0", sample_stb); end
        n_tests++; if (sample_ch !== 3'd0) begin n_fail++; $display("FAIL reset_sample_ch: got %0d expected 0", sample_ch); end
        n_tests++; if (valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h expected 00", valid); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        n_tests++; if (rd_data !== 12'h000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
        n_tests++; if (spi_to_data !== 8'hC0) begin n_fail++; $display("FAIL reset_cmd: got %h expected c0", spi_to_data); end
        n_tests++; if (spi_total_len !== 5'd19) begin n_fail++; $display("FAIL total_len: got %0d expected 19", spi_total_len); end
        do_reset();
    endtask

    task automatic test_single();
        int w; bit ok;
        do_reset();
        enable = 1'b1;
        wait_wr(20, w, ok);
        n_tests++; if (!ok || w != INTERVAL + 1) begin n_fail++; $display("FAIL single_first_wr: got ok=%0d after %0d expected ok=1 after %0d", ok, w, INTERVAL + 1); end
        n_tests++; if (spi_to_data !== 8'hC0) begin n_fail++; $display("FAIL single_cmd: got %h expected c0", spi_to_data); end
        tick();
        n_tests++; if (spi_stb_wr !== 1'b0) begin n_fail++; $display("FAIL single_wr_width: got %b expected 0", spi_stb_wr); end
        spi_stb_rdy = 1'b1; spi_from_data = 12'hA5A;
        tick();
        spi_stb_rdy = 1'b0; spi_from_data = 12'h000;
        n_tests++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL single_early_stb: got %b expected 0", sample_stb); end
        tick();
        rd_addr = 3'd0; #1;
        n_tests++; if (sample_stb !== 1'b1) begin n_fail++; $display("FAIL single_sample_stb: got %b expected 1", sample_stb); end
        n_tests++; if (sample_ch !== 3'd0) begin n_fail++; $display("FAIL single_sample_ch: got %0d expected 0", sample_ch); end
        n_tests++; if (rd_data !== 12'hA5A) begin n_fail++; $display("FAIL single_rd_data: got %h expected a5a", rd_data); end
        n_tests++; if (valid !== 8'h01) begin n_fail++; $display("FAIL single_valid: got %h expected 01", valid); end
        tick();
        n_tests++; if (sample_stb !== 1'b0) begin n_fail++; $display("FAIL single_stb_width: got %b expected 0", sample_stb); end
        enable = 1'b0;
    endtask

    task automatic test_scan();
        int w, prev, a; bit ok;
        logic [7:0]  exp_cmd, exp_cmd4;
        logic [11:0] exp8, exp4;
        do_reset();
        enable = 1'b1;
        prev = 0;
        for (int f = 0; f < 9; f++) begin
            wait_wr(40, w, ok);
            exp_cmd  = {2'b11, 3'(f % 8), 3'b000};
            exp_cmd4 = {2'b11, 3'(f % 4), 3'b000};
            n_tests++; if (!ok || spi_to_data !== exp_cmd) begin n_fail++; $display("FAIL scan_cmd[%0d]: got ok=%0d %h expected %h", f, ok, spi_to_data, exp_cmd); end
            n_tests++; if (spi_stb_wr4 !== 1'b1 || spi_to_data4 !== exp_cmd4) begin n_fail++; $display("FAIL scan_cmd4[%0d]: got %b/%h expected 1/%h", f, spi_stb_wr4, spi_to_data4, exp_cmd4); end
            if (f > 0) begin
                n_tests++; if (cyc - prev != INTERVAL + 3 + 2) begin n_fail++; $display("FAIL scan_spacing[%0d]: got %0d expected %0d", f, cyc - prev, INTERVAL + 5); end
            end
            prev = cyc;
            repeat (3) tick();
            spi_stb_rdy = 1'b1; spi_from_data = 12'(12'h100 + f);
            tick();
            spi_stb_rdy = 1'b0;
        end
        tick();
        tick();
        enable = 1'b0;
        n_tests++; if (sample_cnt != 9) begin n_fail++; $display("FAIL scan_sample_count: got %0d expected 9", sample_cnt); end
        n_tests++; if (valid !== 8'hFF || valid4 !== 4'hF) begin n_fail++; $display("FAIL scan_valid: got %h/%h expected ff/f", valid, valid4); end
        for (a = 0; a < 8; a++) begin
            rd_addr = 3'(a); #1;
            exp8 = (a == 0) ? 12'h108 : 12'(12'h100 + a);
            exp4 = (a >= 4) ? 12'h000 : (a == 0) ? 12'h108 : 12'(12'h104 + a);
            n_tests++; if (rd_data !== exp8) begin n_fail++; $display("FAIL scan_rd[%0d]: got %h expected %h", a, rd_data, exp8); end
            n_tests++; if (rd_data4 !== exp4) begin n_fail++; $display("FAIL scan_rd4[%0d]: got %h expected %h", a, rd_data4, exp4); end
        end
        rd_addr = 3'd0;
    endtask

    task automatic test_timeout();
        int w; bit ok;
        do_reset();
        enable = 1'b1;
        wait_wr(20, w, ok);
        n_tests++; if (!ok || spi_to_data !== 8'hC0) begin n_fail++; $display("FAIL tmo_first_cmd: got ok=%0d %h expected c0", ok, spi_to_data); end
        repeat (TIMEOUT) tick();
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", timeout_err); end
        tick();
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b expected 1", timeout_err); end
        wait_wr(20, w, ok);
        n_tests++; if (!ok || spi_to_data !== 8'hC8) begin n_fail++; $display("FAIL tmo_next_cmd: got ok=%0d %h expected c8", ok, spi_to_data); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", timeout_err); end
        repeat (TIMEOUT - 1) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_clear_collide: got %b expected 1", timeout_err); end
        n_tests++; if (sample_cnt != 0 || valid !== 8'h00) begin n_fail++; $display("FAIL tmo_no_store: got %0d samples valid %h expected 0 / 00", sample_cnt, valid); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int w; bit ok;
        do_reset();
        enable = 1'b1;
        wait_wr(20, w, ok);
        tick();
        enable = 1'b0;
        repeat (2) tick();
        spi_stb_rdy = 1'b1; spi_from_data = 12'h3C3;
        tick();
        spi_stb_rdy = 1'b0;
        tick();
        rd_addr = 3'd0; #1;
        n_tests++; if (sample_stb !== 1'b1 || rd_data !== 12'h3C3) begin n_fail++; $display("FAIL drop_store: got stb=%b data=%h expected 1/3c3", sample_stb, rd_data); end
        n_tests++; if (valid !== 8'h01) begin n_fail++; $display("FAIL drop_valid: got %h expected 01", valid); end
        wr_cnt = 0;
        repeat (30) tick();
        n_tests++; if (wr_cnt != 0) begin n_fail++; $display("FAIL drop_no_wr: got %0d strobes expected 0", wr_cnt); end
    endtask

    task automatic test_reset_midframe();
        int w; bit ok;
        do_reset();
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_wr(20, w, ok);
            tick();
            spi_stb_rdy = 1'b1; spi_from_data = 12'h5E0;
            tick();
            spi_stb_rdy = 1'b0;
        end
        wait_wr(20, w, ok);
        tick();
        n_tests++; if (valid !== 8'h03 || sample_ch !== 3'd1) begin n_fail++; $display("FAIL rst_pre: got valid %h ch %0d expected 03 / 1", valid, sample_ch); end
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        sample_cnt = 0; wr_cnt = 0;
        repeat (3) tick();
        spi_stb_rdy = 1'b1; spi_from_data = 12'hFFF;
        tick();
        spi_stb_rdy = 1'b0;
        repeat (4) tick();
        rd_addr = 3'd0; #1;
        n_tests++; if (sample_cnt != 0 || valid !== 8'h00) begin n_fail++; $display("FAIL rst_no_store: got %0d samples valid %h expected 0 / 00", sample_cnt, valid); end
        n_tests++; if (rd_data !== 12'h000 || sample_ch !== 3'd0) begin n_fail++; $display("FAIL rst_outputs: got data %h ch %0d expected 000 / 0", rd_data, sample_ch); end
        n_tests++; if (wr_cnt != 0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: got wr %0d err %b expected 0 / 0", wr_cnt, timeout_err); end
    endtask

    task automatic test_spurious();
        int w; bit ok;
        do_reset();
        enable = 1'b1;
        repeat (2) tick();
        spi_stb_rdy = 1'b1; spi_from_data = 12'h777;
        tick();
        spi_stb_rdy = 1'b0;
        wait_wr(20, w, ok);
        n_tests++; if (!ok || w != INTERVAL - 2) begin n_fail++; $display("FAIL spur_timing: got ok=%0d after %0d expected ok=1 after %0d", ok, w, INTERVAL - 2); end
        rd_addr = 3'd0; #1;
        n_tests++; if (sample_cnt != 0 || valid !== 8'h00 || rd_data !== 12'h000) begin n_fail++; $display("FAIL spur_no_store: got %0d samples valid %h data %h expected 0 / 00 / 000", sample_cnt, valid, rd_data); end
        enable = 1'b0;
        repeat (TIMEOUT + 4) tick();
    endtask

    initial begin
        repeat (2) tick();
        test_reset();
        test_single();
        test_scan();
        test_timeout();
        test_enable_drop();
        test_reset_midframe();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
